// File: rtl/shift_seq8.sv
// Multi-pass 8-bit shifter/rotator (LSL/LSR/ASR/ROR) doing up to 3 bit positions per SHIFT cycle.
// Latency: done pulses ceil(shamt/3)+1 cycles after start is sampled; shamt=0 goes straight to DONE.
// Backpressure: no queuing; start is ignored while busy, and only an idle block accepts a new request.
module shift_seq8 (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [1:0] op,
    input  logic [7:0] d_in,
    input  logic [2:0] shamt,
    output logic       busy,
    output logic       done,
    output logic [7:0] d_out
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [1:0] OP_LSL = 2'b00;
    localparam logic [1:0] OP_LSR = 2'b01;
    localparam logic [1:0] OP_ASR = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_work;
    logic [2:0] r_rem;
    logic [1:0] r_op;
    logic [7:0] r_result;

    logic [1:0] w_step;
    logic [2:0] w_rem_nxt;
    logic [7:0] w_shifted;

    // Per-pass step: a full 3 while at least 3 remain, otherwise whatever is left.
    always_comb begin
        w_step    = (r_rem >= 3'd3) ? 2'd3 : r_rem[1:0];
        w_rem_nxt = r_rem - {1'b0, w_step};
    end

    // One pass of the selected operation by w_step bit positions.
    always_comb begin
        w_shifted = r_work;
        case (r_op)
            OP_LSL:  w_shifted = r_work << w_step;
            OP_LSR:  w_shifted = r_work >> w_step;
            OP_ASR:  w_shifted = $signed(r_work) >>> w_step;
            OP_ROR:  w_shifted = (r_work >> w_step) | (r_work << (4'd8 - {2'b00, w_step}));
            default: w_shifted = r_work;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and status outputs.
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = (shamt != 3'd0) ? S_SHIFT : S_DONE;
                end
            end
            S_SHIFT: begin
                busy = 1'b1;
                if (w_rem_nxt == 3'd0) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                busy        = 1'b1;
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Operand capture, per-pass update, and result load on the edge that enters DONE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_work   <= 8'h00;
            r_rem    <= 3'd0;
            r_op     <= 2'b00;
            r_result <= 8'h00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_work <= d_in;
                        r_rem  <= shamt;
                        r_op   <= op;
                        // Zero shift bypasses SHIFT, so the operand is already the result.
                        if (shamt == 3'd0) begin
                            r_result <= d_in;
                        end
                    end
                end
                S_SHIFT: begin
                    r_work <= w_shifted;
                    r_rem  <= w_rem_nxt;
                    if (w_rem_nxt == 3'd0) begin
                        r_result <= w_shifted;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign d_out = r_result;

endmodule

// File: tb/tb_shift_seq8.sv
// Bench for shift_seq8: directed operations checked against literals plus a per-cycle reference model.
// Latency: the model expects busy for ceil(n/3)+1 cycles after the accepting edge, done in the last one.
// Backpressure: the model drops any start seen while its busy countdown is non-zero.
module tb_shift_seq8;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic [1:0] op;
    logic [7:0] d_in;
    logic [2:0] shamt;
    logic       busy;
    logic       done;
    logic [7:0] d_out;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: cycles of busy left, pending result, expected d_out.
    int         m_cnt   = 0;
    logic [7:0] m_pend  = 8'h00;
    logic [7:0] m_dout  = 8'h00;

    shift_seq8 dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .d_in    (d_in),
        .shamt   (shamt),
        .busy    (busy),
        .done    (done),
        .d_out   (d_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Whole-shift reference: one shift by n, computed arithmetically.
    function automatic logic [7:0] ref_shift(input logic [1:0] o, input logic [7:0] d, input int n);
        int x;
        int r;
        x = int'(d);
        case (o)
            2'b00:   r = (x << n) & 255;
            2'b01:   r = x >> n;
            2'b10:   begin
                         if (d[7]) x = x - 256;
                         r = (x >>> n) & 255;
                     end
            default: r = ((x >> n) | (x << (8 - n))) & 255;
        endcase
        return r[7:0];
    endfunction

    // Asynchronous reset clears the model immediately.
    always @(negedge reset_n) begin
        m_cnt  = 0;
        m_dout = 8'h00;
    end

    // Advance the model on each rising edge, then compare the DUT shortly after.
    always @(posedge clk) begin
        if (!reset_n) begin
            m_cnt  = 0;
            m_dout = 8'h00;
        end else if (m_cnt == 0) begin
            if (start) begin
                m_pend = ref_shift(op, d_in, int'(shamt));
                m_cnt  = (int'(shamt) + 2) / 3 + 1;
                if (m_cnt == 1) m_dout = m_pend;
            end
        end else begin
            m_cnt = m_cnt - 1;
            if (m_cnt == 1) m_dout = m_pend;
        end
        #2;
        check("model_busy",  32'(busy),  32'(m_cnt > 0));
        check("model_done",  32'(done),  32'(m_cnt == 1));
        check("model_d_out", 32'(d_out), 32'(m_dout));
    end

    // Issue one operation, scramble the inputs while busy, and wait for done.
    task automatic run_op(input logic [1:0] o, input logic [7:0] d, input logic [2:0] n,
                          input logic [7:0] exp_out, input int exp_busy, input string name);
        int  busy_cyc;
        bit  seen;
        @(negedge clk);
        start = 1'b1; op = o; d_in = d; shamt = n;
        @(negedge clk);
        start = 1'b0; op = ~o; d_in = ~d; shamt = ~n;
        busy_cyc = 0;
        seen     = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            if (busy) busy_cyc++;
            if (done) begin
                seen = 1'b1;
                check({name, "_d_out"}, 32'(d_out), 32'(exp_out));
            end
            if (!seen) @(negedge clk);
        end
        check({name, "_done_seen"}, 32'(seen), 32'd1);
        check({name, "_busy_cycles"}, 32'(busy_cyc), 32'(exp_busy));
        @(negedge clk);
        check({name, "_idle_after"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int dones;
        reset_n = 1'b1;
        start   = 1'b0;
        op      = 2'b00;
        d_in    = 8'h00;
        shamt   = 3'd0;

        // Pin the reference function with hand-computed values.
        check("ref_lsl_b3_5", 32'(ref_shift(2'b00, 8'hB3, 5)), 32'h60);
        check("ref_asr_96_7", 32'(ref_shift(2'b10, 8'h96, 7)), 32'hFF);
        check("ref_ror_81_4", 32'(ref_shift(2'b11, 8'h81, 4)), 32'h18);
        check("ref_lsr_96_7", 32'(ref_shift(2'b01, 8'h96, 7)), 32'h01);

        #3 reset_n = 1'b0;
        #1;
        check("reset_busy",  32'(busy),  32'd0);
        check("reset_done",  32'(done),  32'd0);
        check("reset_d_out", 32'(d_out), 32'h00);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        run_op(2'b00, 8'hB3, 3'd5, 8'h60, 3, "lsl_b3_5");
        run_op(2'b10, 8'h96, 3'd7, 8'hFF, 4, "asr_96_7");
        run_op(2'b01, 8'h96, 3'd7, 8'h01, 4, "lsr_96_7");
        run_op(2'b11, 8'h81, 3'd4, 8'h18, 3, "ror_81_4");
        run_op(2'b11, 8'h01, 3'd3, 8'h20, 2, "ror_01_3");
        run_op(2'b01, 8'hF0, 3'd0, 8'hF0, 1, "lsr_f0_0");
        run_op(2'b10, 8'h40, 3'd6, 8'h01, 3, "asr_40_6");

        // A start arriving during SHIFT must be dropped.
        @(negedge clk);
        start = 1'b1; op = 2'b00; d_in = 8'h01; shamt = 3'd6;
        @(negedge clk);
        start = 1'b1; op = 2'b11; d_in = 8'hFF; shamt = 3'd1;
        @(negedge clk);
        start = 1'b0;
        dones = 0;
        for (int k = 0; k < 8; k++) begin
            if (done) begin
                dones++;
                check("ignore_d_out", 32'(d_out), 32'h40);
            end
            @(negedge clk);
        end
        check("ignore_done_count", 32'(dones), 32'd1);
        check("ignore_idle", 32'(busy), 32'd0);
        check("ignore_d_out_held", 32'(d_out), 32'h40);

        // Reset in the middle of an operation aborts it at once.
        @(negedge clk);
        start = 1'b1; op = 2'b10; d_in = 8'h80; shamt = 3'd7;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midrst_busy",  32'(busy),  32'd0);
        check("midrst_done",  32'(done),  32'd0);
        check("midrst_d_out", 32'(d_out), 32'h00);
        @(negedge clk);
        check("midrst_no_done", 32'(done), 32'd0);
        reset_n = 1'b1;
        run_op(2'b00, 8'h03, 3'd2, 8'h0C, 2, "post_rst_lsl_03_2");

        @(negedge clk);
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_seq8.md
SHIFT_SEQ8 -- requirements
Module: shift_seq8

Interface
REQ-001 Parameters: none; data width fixed at 8 bits, shift amount fixed at 3 bits.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request to begin an operation; sampled only in IDLE.
REQ-005 op  input  2  operation: 00 LSL, 01 LSR, 10 ASR, 11 ROR.
REQ-006 d_in  input  8  operand; sampled together with start.
REQ-007 shamt  input  3  total shift amount 0..7; sampled together with start.
REQ-008 busy  output  1  high while an operation is in progress (states SHIFT and DONE).
REQ-009 done  output  1  one-cycle pulse; result valid on d_out.
REQ-010 d_out  output  8  registered result of the most recent completed operation.

Function
REQ-011 The block SHALL be a three-state FSM: IDLE, SHIFT, DONE.
REQ-012 Internal registers: work[7:0], rem[2:0], op_q[1:0], result[7:0]; d_out SHALL be driven directly from result.
REQ-013 IDLE with start=1 at an edge: the block SHALL latch work<=d_in, rem<=shamt, op_q<=op; next state SHIFT if shamt!=0, else DONE.
REQ-014 IDLE with start=0: the block SHALL hold all registers.
REQ-015 SHIFT, each edge: step = 3 if rem>=3, else rem; work <= shift(work, op_q, step); rem <= rem-step.
REQ-016 SHIFT exits to DONE on the edge where rem-step==0; otherwise it remains in SHIFT.
REQ-017 Per-pass shift by step 0..3: LSL fills zeros at the LSB; LSR fills zeros at the MSB; ASR replicates work[7]; ROR rotates work[0..step-1] into the MSBs.
REQ-018 Passes: shift amount n takes ceil(n/3) SHIFT cycles (n=7 -> 3,3,1; n=5 -> 3,2; n=4 -> 3,1); the combined result SHALL equal a single shift by n.
REQ-019 On the edge entering DONE, the block SHALL load result<=final work value, so d_out changes only on that edge.
REQ-020 DONE: done=1 for exactly one cycle; the next edge returns to IDLE unconditionally.
REQ-021 Latency, start sampled at edge E0: done is high in the cycle following edge E(ceil(n/3)); n=0 -> done in the cycle after E0.
REQ-022 start asserted in SHIFT or DONE SHALL be ignored, with no queuing; a new start is accepted only in IDLE; back-to-back throughput is one operation per ceil(n/3)+2 cycles.
REQ-023 op, d_in and shamt changing while busy=1 SHALL NOT affect the operation in flight.
REQ-024 busy SHALL be high in SHIFT and DONE and low in IDLE; done SHALL be high only in DONE.

Reset
REQ-025 reset_n=0 SHALL immediately force state IDLE, busy=0, done=0, d_out=8'h00, work=0, rem=0, op_q=0, regardless of clk.
REQ-026 Reset asserted mid-operation SHALL abort the operation, produce no done pulse, and clear d_out to 8'h00.
REQ-027 After reset_n rises, the first edge with start=1 SHALL be accepted normally.

Verification
REQ-028 LSL, d_in=8'hB3, shamt=5, start=1 -> 2 SHIFT cycles, then done=1 with d_out=8'h60; busy is high for 3 cycles total.
REQ-029 ASR, d_in=8'h96, shamt=7 -> passes 3,3,1, then done with d_out=8'hFF; repeat with LSR, d_in=8'h96, shamt=7 -> d_out=8'h01.
REQ-030 ROR, d_in=8'h81, shamt=4 -> d_out=8'h18 after 2 SHIFT cycles; ROR, d_in=8'h01, shamt=3 -> d_out=8'h20 after 1 SHIFT cycle.
REQ-031 LSR, d_in=8'hF0, shamt=0 -> no SHIFT cycle; done in the cycle after start with d_out=8'hF0.
REQ-032 Start ignored while busy: start LSL 8'h01 by 6, then pulse start with ROR 8'hFF by 1 during SHIFT -> single done with d_out=8'h40, busy falls normally, and the second request is not executed.
REQ-033 Reset mid-op: start ASR 8'h80 by 7, drive reset_n=0 after the first SHIFT edge -> busy=0, done=0, d_out=8'h00 immediately; after release, LSL 8'h03 by 2 -> d_out=8'h0C.
